serial_frame_tx: RTL and testbench

Upstream serial transmitter feeding the serial register-bank loader.
- After reset, reads every entry of a source register bank (DEPTH x DATA_W).
- Sends each entry as one serial frame on sen/sd: ADDR_W address bits MSB-first, then DATA_W data bits MSB-first.
- Asserts done once all entries are sent.
- Runs autonomously; no start input.

---
 rtl/serial_frame_tx_pkg.sv | 32 +++
 rtl/serial_frame_tx_if.sv | 23 ++
 rtl/serial_frame_tx_frame_piso.sv | 31 +++
 rtl/serial_frame_tx.sv | 99 +++++++++
 tb/tb_serial_frame_tx.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its receiving loader.
// Frame format: ADDR_W address bits MSB-first, then DATA_W data bits MSB-first.
package serial_frame_tx_pkg;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 18;
    localparam int DEPTH   = 8;
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int IDX_W   = ADDR_W + 1;
    localparam int CNT_W   = $clog2(FRAME_W);

    // Serial line levels and framing.
    localparam logic SEN_ACTIVE = 1'b0;
    localparam logic SEN_IDLE   = 1'b1;
    localparam int   GAP_CYCLES = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } tx_state_e;

    // Assemble one frame word: address in the top bits, data below.
    function automatic logic [FRAME_W-1:0] frame_word(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {addr, data};
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Bank-read and serial-line signals of the frame transmitter.
// master = transmitter side, slave = bank model / serial receiver side.
interface serial_frame_tx_if;
    import serial_frame_tx_pkg::*;

    logic              rb_rw;
    logic [ADDR_W-1:0] rb_a;
    logic [DATA_W-1:0] rb_q;
    logic              sen;
    logic              sd;
    logic              done;

    modport master (
        output rb_rw, rb_a, sen, sd, done,
        input  rb_q
    );

    modport slave (
        input  rb_rw, rb_a, sen, sd, done,
        output rb_q
    );

endinterface

// File: rtl/serial_frame_tx_frame_piso.sv
// FRAME_W-bit parallel-load, MSB-first shift register. Zeros shift in at the
// bottom, so once a whole frame has been shifted out the MSB rests at 0.
module frame_piso
    import serial_frame_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [FRAME_W-1:0] i_data,
    output logic               o_msb
);

    logic [FRAME_W-1:0] r_q;

    // Load has priority over shift; otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[FRAME_W-2:0], 1'b0};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_msb = r_q[FRAME_W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Autonomous serial frame transmitter: after reset it reads every bank entry
// once and sends it as a frame on sen/sd, then raises a sticky done flag.
// sd comes straight from the shift-register MSB, so it is a flop output with
// no path from rb_q.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    serial_frame_tx_if.master  bus
);

    tx_state_e         r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rb_a;
    logic              r_rb_rw;
    logic              r_sen;
    logic              r_done;

    logic               w_load;
    logic               w_shift;
    logic               w_msb;
    logic [IDX_W-1:0]   w_idx_next;
    logic [FRAME_W-1:0] w_frame;

    assign w_load     = (r_state == S_LOAD);
    // Shifting continues through the final SHIFT edge so the line drops to 0 in the gap.
    assign w_shift    = (r_state == S_SHIFT);
    assign w_idx_next = r_idx + IDX_W'(1);
    assign w_frame    = frame_word(r_idx[ADDR_W-1:0], bus.rb_q);

    frame_piso u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_frame),
        .o_msb   (w_msb)
    );

    // Sequencer: IDLE -> (LOAD -> SHIFT) per entry -> DONE. r_cnt counts the
    // shifts still to come, so SHIFT lasts FRAME_W cycles including the LOAD bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rb_a  <= '0;
            r_rb_rw <= 1'b1;
            r_sen   <= SEN_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_rb_rw <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_rb_a  <= '0;
                    r_sen   <= SEN_IDLE;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_sen   <= SEN_ACTIVE;
                    r_cnt   <= CNT_W'(FRAME_W - 1);
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_sen <= SEN_IDLE;
                        if (r_idx == IDX_W'(DEPTH - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_idx_next;
                            r_rb_a  <= w_idx_next[ADDR_W-1:0];
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_sen  <= SEN_IDLE;
                    r_done <= 1'b1;
                end
                default: begin
                    r_sen   <= SEN_IDLE;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rb_rw = r_rb_rw;
    assign bus.rb_a  = r_rb_a;
    assign bus.sen   = r_sen;
    assign bus.sd    = w_msb;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx. The reference is a timeline model:
// after reset release, edge 1 is the idle step, then each entry occupies 22
// edges (21 frame bits + 1 gap) and done is up from edge 1+22*DEPTH onward.
module tb_serial_frame_tx;
    import serial_frame_tx_pkg::*;

    localparam int PERIOD   = FRAME_W + GAP_CYCLES;
    localparam int DONE_EDG = 1 + PERIOD * DEPTH;

    logic clk;
    logic rst;
    logic [DATA_W-1:0] bank [DEPTH];
    logic [DATA_W-1:0] noise;
    logic              noise_en;
    int checks;
    int errors;

    serial_frame_tx_if bus ();

    serial_frame_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: combinational read; optional garbage while a frame is on the line.
    always_comb begin
        if (noise_en && (bus.sen == 1'b0)) begin
            bus.rb_q = noise;
        end else begin
            bus.rb_q = bank[bus.rb_a];
        end
    end

    // Fresh garbage every cycle.
    always @(negedge clk) noise <= DATA_W'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Follow the timeline for edges 1..n_edges after release, checking every edge.
    task automatic run_edges(input int n_edges);
        logic [FRAME_W-1:0] frame;
        logic exp_sen, exp_sd, exp_done;
        int   exp_a, k, e, pos;
        for (int n = 1; n <= n_edges; n++) begin
            @(posedge clk);
            #1;
            exp_sen = 1'b1; exp_sd = 1'b0; exp_a = 0;
            if (n >= 2) begin
                k = n - 2; e = k / PERIOD; pos = k % PERIOD;
                if (e >= DEPTH) begin
                    exp_a = DEPTH - 1;
                end else if (pos < FRAME_W) begin
                    frame   = {e[ADDR_W-1:0], bank[e]};
                    exp_sen = 1'b0;
                    exp_sd  = frame[FRAME_W-1-pos];
                    exp_a   = e;
                end else begin
                    exp_a = (e == DEPTH - 1) ? e : e + 1;
                end
            end
            exp_done = (n >= DONE_EDG);
            chk("sen",   32'(bus.sen),   32'(exp_sen));
            chk("sd",    32'(bus.sd),    32'(exp_sd));
            chk("done",  32'(bus.done),  32'(exp_done));
            chk("rb_a",  32'(bus.rb_a),  32'(exp_a));
            chk("rb_rw", 32'(bus.rb_rw), 32'd1);
        end
    endtask

    // Hold reset for a couple of cycles, check reset values, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sen",   32'(bus.sen),   32'd1);
        chk("rst_sd",    32'(bus.sd),    32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_rb_a",  32'(bus.rb_a),  32'd0);
        chk("rst_rb_rw", 32'(bus.rb_rw), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] plan [DEPTH];
        checks   = 0;
        errors   = 0;
        noise_en = 1'b0;
        rst      = 1'b1;
        plan[0] = 18'h00001; plan[1] = 18'h3FFFF; plan[2] = 18'h12345; plan[3] = 18'h00000;
        plan[4] = 18'h20000; plan[5] = 18'h1FFFF; plan[6] = 18'h0F0F0; plan[7] = 18'h3C3C3;

        // Alternating pattern bank, full run plus 50 cycles of held done.
        for (int i = 0; i < DEPTH; i++) bank[i] = 18'h2AAAA ^ DATA_W'(i);
        do_reset();
        run_edges(DONE_EDG + 50);

        // Directed corner values.
        for (int i = 0; i < DEPTH; i++) bank[i] = plan[i];
        do_reset();
        run_edges(DONE_EDG + 50);

        // Random bank with rb_q scrambled whenever a frame is on the line.
        for (int i = 0; i < DEPTH; i++) bank[i] = DATA_W'($urandom);
        noise_en = 1'b1;
        do_reset();
        run_edges(DONE_EDG + 5);
        noise_en = 1'b0;

        // Abort inside frame 3 at bit 10, then check a clean restart from entry 0.
        for (int i = 0; i < DEPTH; i++) bank[i] = DATA_W'($urandom);
        do_reset();
        run_edges(2 + PERIOD * 3 + 10);
        chk("pre_abort_sen", 32'(bus.sen), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_sen",  32'(bus.sen),  32'd1);
        chk("abort_sd",   32'(bus.sd),   32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rb_a", 32'(bus.rb_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_edges(DONE_EDG + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
